// File: rtl/cnn_pkg.sv
// Shared CNN definitions: pooled-pixel width, pooling row-phase state and the ReLU/narrow helper.
// Optional CONV2_POOL_SAT_EN makes the narrow step saturate instead of truncate.
package cnn_pkg;

    localparam int POOL_OUT_BITS = 12;
    localparam logic [POOL_OUT_BITS-1:0] POOL_SAT_MAX = 12'hFFF;

    typedef enum logic {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } pool_state_t;

    // Callers sign-extend their sample to 32 bits so conv1 and conv2 stages share this.
    function automatic logic [POOL_OUT_BITS-1:0] relu_narrow(input logic signed [31:0] x);
        logic [POOL_OUT_BITS-1:0] r;
        if (x < 0)
            r = '0;
`ifdef CONV2_POOL_SAT_EN
        else if (x > $signed({20'd0, POOL_SAT_MAX}))
            r = POOL_SAT_MAX;
`endif
        else
            r = x[POOL_OUT_BITS-1:0];
        return r;
    endfunction

    function automatic logic [POOL_OUT_BITS-1:0] umax(input logic [POOL_OUT_BITS-1:0] a,
                                                      input logic [POOL_OUT_BITS-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv2_maxpool_relu_if.sv
// Pixel stream into and pooled stream out of the conv2 ReLU/max-pool stage.
interface conv2_maxpool_relu_if
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = 14
);
    logic                        valid_in;
    logic signed [DATA_BITS-1:0] conv_in_1;
    logic signed [DATA_BITS-1:0] conv_in_2;
    logic signed [DATA_BITS-1:0] conv_in_3;
    logic [POOL_OUT_BITS-1:0]    max_out_1;
    logic [POOL_OUT_BITS-1:0]    max_out_2;
    logic [POOL_OUT_BITS-1:0]    max_out_3;
    logic                        valid_out;
    logic                        frame_done;

    modport master (
        output valid_in, conv_in_1, conv_in_2, conv_in_3,
        input  max_out_1, max_out_2, max_out_3, valid_out, frame_done
    );

    modport slave (
        input  valid_in, conv_in_1, conv_in_2, conv_in_3,
        output max_out_1, max_out_2, max_out_3, valid_out, frame_done
    );
endinterface

// File: rtl/maxpool_line_buf.sv
// One channel's row of horizontal pair maxima, kept from an even row for use in the odd row below it.
module maxpool_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [IW-1:0]            wr_idx,
    input  logic [POOL_OUT_BITS-1:0] wr_data,
    input  logic [IW-1:0]            rd_idx,
    output logic [POOL_OUT_BITS-1:0] rd_data
);
    logic [POOL_OUT_BITS-1:0] mem [DEPTH];

    // NOTE: no reset on the storage; every entry is written in an even row before it is read.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_data;
    end

    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/conv2_maxpool_relu.sv
// conv2 ReLU + non-overlapping 2x2 max-pool over three lockstep channels, raster-order input.
// CONV2_POOL_SAT_EN selects saturating (vs truncating) narrowing of the ReLU result to 12 bits.
module conv2_maxpool_relu
    import cnn_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int DATA_BITS = 14
) (
    input  logic                 clk,
    input  logic                 rst_n,
    conv2_maxpool_relu_if.slave  bus
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW   = (HALF   > 1) ? $clog2(HALF)   : 1;

    logic [CW-1:0]               col;
    logic [RW-1:0]               row;
    pool_state_t                 state, state_next;
    logic                        last_col, last_row, wr_en, out_fire;
    logic [IW-1:0]               pair_idx;
    logic signed [DATA_BITS-1:0] x        [3];
    logic [POOL_OUT_BITS-1:0]    r        [3];
    logic [POOL_OUT_BITS-1:0]    hold     [3];
    logic [POOL_OUT_BITS-1:0]    pair_max [3];
    logic [POOL_OUT_BITS-1:0]    rd_data  [3];
    logic [POOL_OUT_BITS-1:0]    pool_max [3];
    logic [POOL_OUT_BITS-1:0]    out_q    [3];
    logic                        valid_q, done_q;

    assign x[0]     = bus.conv_in_1;
    assign x[1]     = bus.conv_in_2;
    assign x[2]     = bus.conv_in_3;
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == RW'(HEIGHT - 1));
    assign pair_idx = IW'(col >> 1);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        out_fire   = 1'b0;
        case (state)
            EVEN_ROW: begin
                wr_en = bus.valid_in && col[0];
                if (bus.valid_in && last_col)
                    state_next = ODD_ROW;
            end
            ODD_ROW: begin
                out_fire = bus.valid_in && col[0];
                if (bus.valid_in && last_col)
                    state_next = EVEN_ROW;
            end
            default: state_next = EVEN_ROW;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            r[i]        = relu_narrow(32'(x[i]));
            pair_max[i] = umax(hold[i], r[i]);
            pool_max[i] = umax(pair_max[i], rd_data[i]);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_lb
        maxpool_line_buf #(.DEPTH(HALF)) u_lb (
            .clk     (clk),
            .wr_en   (wr_en),
            .wr_idx  (pair_idx),
            .wr_data (pair_max[g]),
            .rd_idx  (pair_idx),
            .rd_data (rd_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= EVEN_ROW;
        else
            state <= state_next;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hold[i]  <= '0;
                out_q[i] <= '0;
            end
        end else begin
            valid_q <= out_fire;
            done_q  <= out_fire && last_col && last_row;
            for (int i = 0; i < 3; i++) begin
                if (bus.valid_in && !col[0])
                    hold[i] <= r[i];
                if (out_fire)
                    out_q[i] <= pool_max[i];
            end
            if (bus.valid_in) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign bus.max_out_1  = out_q[0];
    assign bus.max_out_2  = out_q[1];
    assign bus.max_out_3  = out_q[2];
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Directed bench for conv2_maxpool_relu: hand-computed pooled values, output timing and reset abort.
module tb_conv2_maxpool_relu;
    import cnn_pkg::*;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int DB   = 14;
    localparam int NWIN = (W / 2) * (H / 2);

    localparam int M_CONST = 0;
    localparam int M_NEG   = 1;
    localparam int M_RAMP  = 2;
    localparam int M_SPIKE = 3;
`ifdef CONV2_POOL_SAT_EN
    localparam int SPIKE_EXP = 4095;
`else
    localparam int SPIKE_EXP = 904;
`endif

    typedef struct packed {
        logic [11:0] v1;
        logic [11:0] v2;
        logic [11:0] v3;
        logic        fd;
        int          stamp;
    } pool_rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv2_maxpool_relu_if #(.DATA_BITS(DB)) bus ();

    conv2_maxpool_relu #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pool_rec_t obs_q[$];
    pool_rec_t exp_q[$];
    pool_rec_t mon_rec;
    int n_cmp    = 0;
    int n_err    = 0;
    int pix_cnt  = 0;
    int stray_fd = 0;
    // Bottom-right element of each 2x2 window of value row*8+col.
    int ramp_tbl [NWIN] = '{9, 11, 13, 15, 25, 27, 29, 31, 41, 43, 45, 47, 57, 59, 61, 63};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs change only at posedge; sample them 2 time units later.
    always @(posedge clk) begin
        #2;
        if (bus.valid_out) begin
            mon_rec.v1    = bus.max_out_1;
            mon_rec.v2    = bus.max_out_2;
            mon_rec.v3    = bus.max_out_3;
            mon_rec.fd    = bus.frame_done;
            mon_rec.stamp = pix_cnt;
            obs_q.push_back(mon_rec);
        end else if (bus.frame_done) begin
            stray_fd++;
        end
    end

    function automatic logic signed [DB-1:0] pix_val(input int mode, input int r, input int c,
                                                     input int ch);
        int v;
        case (mode)
            M_CONST: v = 100;
            M_NEG:   v = -50;
            M_RAMP:  v = (ch == 0) ? (r * W + c) : -(r * W + c);
            default: v = (r == 2 && c == 3) ? 5000 : 0;
        endcase
        return DB'(v);
    endfunction

    function automatic int exp_val(input int mode, input int w, input int ch);
        case (mode)
            M_CONST: return 100;
            M_NEG:   return 0;
            M_RAMP:  return (ch == 0) ? ramp_tbl[w] : 0;
            default: return (w == 5) ? SPIKE_EXP : 0;
        endcase
    endfunction

    task automatic drive_pixel(input int mode, input int r, input int c);
        @(negedge clk);
        bus.valid_in  = 1'b1;
        bus.conv_in_1 = pix_val(mode, r, c, 0);
        bus.conv_in_2 = pix_val(mode, r, c, 1);
        bus.conv_in_3 = pix_val(mode, r, c, 2);
        pix_cnt       = r * W + c + 1;
    endtask

    // Idle cycles carry junk data that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in  = 1'b0;
            bus.conv_in_1 = DB'($urandom);
            bus.conv_in_2 = DB'($urandom);
            bus.conv_in_3 = DB'($urandom);
        end
    endtask

    task automatic push_exp(input int mode, input int w);
        pool_rec_t rec;
        rec.v1    = 12'(exp_val(mode, w, 0));
        rec.v2    = 12'(exp_val(mode, w, 1));
        rec.v3    = 12'(exp_val(mode, w, 2));
        rec.fd    = (w == NWIN - 1);
        rec.stamp = (2 * (w / (W / 2)) + 1) * W + 2 * (w % (W / 2)) + 2;
        exp_q.push_back(rec);
    endtask

    // gap: 0 = none, 1 = one idle cycle after every pixel, 2 = random 0..5 idle cycles.
    task automatic run_frame(input int mode, input int gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive_pixel(mode, r, c);
                if (gap == 1)
                    idle(1);
                else if (gap == 2)
                    idle($urandom_range(0, 5));
            end
        end
        for (int w = 0; w < NWIN; w++)
            push_exp(mode, w);
    endtask

    task automatic flush_and_compare(input string tag);
        int n;
        idle(4);
        check($sformatf("%s.count", tag), obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d].ch1", tag, i), obs_q[i].v1, exp_q[i].v1);
            check($sformatf("%s[%0d].ch2", tag, i), obs_q[i].v2, exp_q[i].v2);
            check($sformatf("%s[%0d].ch3", tag, i), obs_q[i].v3, exp_q[i].v3);
            check($sformatf("%s[%0d].frame_done", tag, i), obs_q[i].fd, exp_q[i].fd);
            check($sformatf("%s[%0d].after_pixel", tag, i), obs_q[i].stamp, exp_q[i].stamp);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".valid_out"},  bus.valid_out,  0);
        check({tag, ".frame_done"}, bus.frame_done, 0);
        check({tag, ".max_out_1"},  bus.max_out_1,  0);
        check({tag, ".max_out_2"},  bus.max_out_2,  0);
        check({tag, ".max_out_3"},  bus.max_out_3,  0);
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.conv_in_1 = '0;
        bus.conv_in_2 = '0;
        bus.conv_in_3 = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        run_frame(M_CONST, 0);
        flush_and_compare("const100");
        run_frame(M_NEG, 0);
        flush_and_compare("neg50");
        run_frame(M_RAMP, 0);
        flush_and_compare("ramp");
        run_frame(M_SPIKE, 0);
        flush_and_compare("spike");

        // Back-to-back frames with input gaps must match the gap-free results.
        run_frame(M_RAMP, 1);
        run_frame(M_CONST, 2);
        run_frame(M_SPIKE, 2);
        run_frame(M_RAMP, 0);
        flush_and_compare("gaps");

        // Abort a frame after 20 pixels; its first pooled row is already out.
        for (int i = 0; i < 20; i++)
            drive_pixel(M_CONST, i / W, i % W);
        for (int w = 0; w < 4; w++)
            push_exp(M_CONST, w);
        flush_and_compare("partial");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst_n = 1'b1;
        run_frame(M_RAMP, 0);
        flush_and_compare("post_reset");

        check("stray_frame_done", stray_fd, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
